hazard_control_unit: RTL and testbench

- Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB). It generates all stall and flush controls for the pipeline registers.
- It pairs with the forwarding unit and covers what forwarding cannot resolve:
  - load-use hazards
  - taken-branch squash
  - multi-cycle data-memory waits, with a timeout
  - halt drain
- Sits beside the datapath. It has no datapath inputs other than register addresses and control flags.

---
 rtl/hazard_control_unit.sv | 207 ++++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash, memory waits with timeout, halt drain.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rt_ID,
  input  logic        mem_read_EX,
  input  logic [4:0]  write_addr_EX,
  input  logic        branch_taken_EX,
  input  logic        halt_ID,
  input  logic        mem_req_MEM,
  input  logic        mem_ack,
  input  logic        start,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        flush_ID,
  output logic        flush_EX,
  output logic        bubble_WB,
  output logic        halted,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] load_use_cnt,
  output logic [31:0] mem_stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        mem_error
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RUN, S_DRAIN, S_HALTED, S_MEM_WAIT, S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           resume_q, resume_d;
  logic           halted_q, halted_d;
  logic           mem_error_q, mem_error_d;

  logic mem_busy, load_use, draining, frozen;
  logic lu_bubble, br_flush;

  assign mem_busy = mem_req_MEM & ~mem_ack;
  assign load_use = mem_read_EX & (write_addr_EX != 5'd0) &
                    ((write_addr_EX == rs_ID) | (uses_rt_ID & (write_addr_EX == rt_ID)));
  assign frozen   = (state_q == S_ERROR) | (state_q == S_HALTED);
  // The ack cycle of a wait taken during drain still behaves (and counts) as a drain cycle.
  assign draining = (state_q == S_DRAIN) | ((state_q == S_MEM_WAIT) & resume_q);

  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    bubble_WB = 1'b0;
    lu_bubble = 1'b0;
    br_flush  = 1'b0;
    if (rst_n) begin
      if (frozen || mem_busy) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        stall_EX  = 1'b1;
        stall_MEM = 1'b1;
        bubble_WB = 1'b1;
      end else if (branch_taken_EX) begin
        flush_ID = 1'b1;
        flush_EX = 1'b1;
        br_flush = 1'b1;
      end else if (load_use && state_q == S_RUN) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        flush_EX  = 1'b1;
        lu_bubble = 1'b1;
      end else if (draining) begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        flush_EX = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    resume_d    = resume_q;
    halted_d    = halted_q;
    mem_error_d = mem_error_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WCW'(1);
          resume_d   = 1'b0;
        end else if (halt_ID && !branch_taken_EX) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          wait_cnt_d = '0;
          resume_d   = 1'b0;
          if (!resume_q) begin
            state_d = S_RUN;
          end else if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = drain_cnt_q + DCW'(1);
          end
        end else if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) begin
          state_d     = S_ERROR;
          mem_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      S_DRAIN: begin
        if (mem_busy) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WCW'(1);
          resume_d   = 1'b1;
        end else if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d  = S_RUN;
          halted_d = 1'b0;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      resume_q    <= 1'b0;
      halted_q    <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      resume_q    <= resume_d;
      halted_q    <= halted_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign halted    = halted_q;
  assign mem_error = mem_error_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] load_use_cnt_q, load_use_cnt_d;
  logic [31:0] mem_stall_cnt_q, mem_stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event strobes are already zero in HALTED/ERROR, so counters freeze there.
  always_comb begin
    load_use_cnt_d  = load_use_cnt_q  + {31'd0, lu_bubble};
    mem_stall_cnt_d = mem_stall_cnt_q + {31'd0, mem_busy & ~frozen};
    flush_cnt_d     = flush_cnt_q     + {31'd0, br_flush};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_use_cnt_q  <= '0;
      mem_stall_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      load_use_cnt_q  <= load_use_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign load_use_cnt  = load_use_cnt_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = lu_bubble ^ br_flush;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit (MEM_TIMEOUT=8, DRAIN_CYCLES=3).
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_ID, rt_ID, write_addr_EX;
  logic       uses_rt_ID, mem_read_EX, branch_taken_EX, halt_ID;
  logic       mem_req_MEM, mem_ack, start;
  logic       stall_IF, stall_ID, stall_EX, stall_MEM;
  logic       flush_ID, flush_EX, bubble_WB, halted, mem_error;

  int n_vec = 0;
  int n_err = 0;

  hazard_control_unit #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .mem_read_EX(mem_read_EX), .write_addr_EX(write_addr_EX),
    .branch_taken_EX(branch_taken_EX), .halt_ID(halt_ID),
    .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack), .start(start),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .bubble_WB(bubble_WB),
    .halted(halted), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  // {stall_IF,stall_ID,stall_EX,stall_MEM,flush_ID,flush_EX,bubble_WB,halted,mem_error}
  logic [8:0] obs;
  assign obs = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, bubble_WB, halted, mem_error};

  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] DR   = 9'b110001000;
  localparam logic [8:0] BR   = 9'b000011000;
  localparam logic [8:0] MB   = 9'b111100100;
  localparam logic [8:0] HLT  = 9'b111100110;
  localparam logic [8:0] ERR  = 9'b111100101;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_chk(input string tag, input logic [8:0] exp);
    #3;
    chk(tag, obs, exp);
  endtask

  task automatic idle();
    rs_ID = 5'd0; rt_ID = 5'd0; uses_rt_ID = 1'b0; mem_read_EX = 1'b0;
    write_addr_EX = 5'd0; branch_taken_EX = 1'b0; halt_ID = 1'b0;
    mem_req_MEM = 1'b0; mem_ack = 1'b0; start = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt, input logic urt);
    mem_read_EX = 1'b1; write_addr_EX = wa; rs_ID = rs; rt_ID = rt; uses_rt_ID = urt;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    set_lu(5'd5, 5'd5, 5'd0, 1'b0);
    settle_chk("rst_forces_zero", NONE);
    cyc(); cyc();
    rst_n = 1'b1; idle();
    settle_chk("reset_state", NONE);

    // load-use on rs, then hazard gone
    cyc(); set_lu(5'd5, 5'd5, 5'd0, 1'b0);
    settle_chk("lu_rs", LU);
    cyc(); idle();
    settle_chk("lu_one_bubble", NONE);
    cyc(); set_lu(5'd5, 5'd1, 5'd5, 1'b1);
    settle_chk("lu_rt", LU);
    cyc(); set_lu(5'd5, 5'd1, 5'd5, 1'b0);
    settle_chk("lu_rt_unused", NONE);
    cyc(); set_lu(5'd0, 5'd0, 5'd0, 1'b1);
    settle_chk("lu_r0", NONE);
    cyc(); set_lu(5'd7, 5'd7, 5'd0, 1'b0); branch_taken_EX = 1'b1;
    settle_chk("branch_over_lu", BR);
    cyc(); idle(); start = 1'b1;
    settle_chk("start_in_run", NONE);

    // memory wait: 4 busy cycles, first one with a branch pending
    cyc(); idle(); mem_req_MEM = 1'b1; branch_taken_EX = 1'b1;
    settle_chk("memwait_c1_branch", MB);
    for (int i = 2; i <= 4; i++) begin
      cyc(); branch_taken_EX = 1'b0;
      settle_chk($sformatf("memwait_c%0d", i), MB);
    end
    cyc(); mem_ack = 1'b1;
    settle_chk("memwait_ack", NONE);
    cyc(); idle(); set_lu(5'd3, 5'd3, 5'd0, 1'b0);
    settle_chk("memwait_back_run", LU);

    // halt drain with a 2-cycle memory wait inside
    cyc(); idle(); halt_ID = 1'b1;
    settle_chk("halt_in_run", NONE);
    cyc(); idle();
    settle_chk("drain0", DR);
    cyc(); mem_req_MEM = 1'b1;
    settle_chk("drain_busy1", MB);
    cyc();
    settle_chk("drain_busy2", MB);
    cyc(); mem_ack = 1'b1;
    settle_chk("drain_ack", DR);
    cyc(); idle();
    settle_chk("drain2", DR);
    cyc();
    settle_chk("halted", HLT);
    cyc(); set_lu(5'd4, 5'd4, 5'd0, 1'b0); branch_taken_EX = 1'b1; mem_req_MEM = 1'b1;
    settle_chk("halted_masks", HLT);
    cyc(); idle(); start = 1'b1;
    settle_chk("halted_start", HLT);
    cyc(); idle();
    settle_chk("resumed", NONE);

    // reset at drain count 1
    cyc(); halt_ID = 1'b1;
    settle_chk("halt2", NONE);
    cyc(); idle();
    settle_chk("drain2_0", DR);
    cyc();
    settle_chk("drain2_1", DR);
    rst_n = 1'b0;
    settle_chk("drain_rst_comb", NONE);
    cyc(); rst_n = 1'b1;
    settle_chk("after_drain_rst", NONE);
    cyc();
    settle_chk("after_drain_rst2", NONE);
    set_lu(5'd9, 5'd1, 5'd9, 1'b1);
    settle_chk("after_drain_rst_run", LU);

    // timeout: 8 busy cycles then ERROR
    cyc(); idle(); mem_req_MEM = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      settle_chk($sformatf("timeout_c%0d", i), MB);
      cyc();
    end
    settle_chk("timeout_err", ERR);
    mem_ack = 1'b1;
    settle_chk("err_ignores_ack", ERR);
    cyc(); idle(); start = 1'b1;
    settle_chk("err_sticky", ERR);
    rst_n = 1'b0;
    settle_chk("err_rst_comb", 9'b000000001);
    cyc(); idle();
    settle_chk("err_rst_edge", NONE);
    rst_n = 1'b1;
    cyc();
    settle_chk("err_cleared", NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
